// File: rtl/key_event_queue.sv
// Press-edge detector and event FIFO for the 4-button active-low interface.
// Optional build macro KEY_RELEASE_EN also queues release edges as {rel, key} entries.
module key_event_queue_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press,
    output logic rel
);
    logic prev;

    // prev resets to "released" so a button held through reset shows as a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= btn;
    end

    assign press = prev & ~btn;
    assign rel   = ~prev & btn;
endmodule

module key_event_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       button_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_key,
    output logic             evt_rel,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
    input  logic             ovf_clr
);
`ifdef KEY_RELEASE_EN
    localparam int NC = 8;
`else
    localparam int NC = 4;
`endif
    localparam int IW = $clog2(NC);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]       press, rel;
    logic [NC-1:0]    edge_v, pending, cand, push_oh, pending_nxt;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop, can_push, push_en, ovf_set;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_event_queue_edge u_edge (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (button_in[k]),
            .press (press[k]),
            .rel   (rel[k])
        );
    end

`ifdef KEY_RELEASE_EN
    assign edge_v = {rel, press};
`else
    assign edge_v = press;
`endif

    // Candidate index doubles as the stored entry: bit 2 = release, bits 1:0 = key
    assign cand     = pending | edge_v;
    assign pop      = (count != '0) & evt_ready;
    assign can_push = (count < CNT_W'(DEPTH)) | pop;
    assign push_en  = can_push & (|cand);
    assign ovf_set  = |(pending & edge_v);

    always_comb begin
        push_idx = '0;
        for (int i = NC - 1; i >= 0; i--) begin
            if (cand[i]) push_idx = IW'(i);
        end
    end

    assign push_oh     = {{(NC-1){1'b0}}, 1'b1} << push_idx;
    assign pending_nxt = push_en ? (cand & ~push_oh) : cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            pending <= pending_nxt;
            if (push_en) begin
                mem[wr_ptr] <= push_idx;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_en && !pop)      count <= count + 1'b1;
            else if (!push_en && pop) count <= count - 1'b1;
            // a fresh merge in the same cycle outranks the clear
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign evt_valid = (count != '0);
    assign evt_count = count;
    assign evt_key   = mem[rd_ptr][1:0];
`ifdef KEY_RELEASE_EN
    assign evt_rel   = mem[rd_ptr][2];
`else
    assign evt_rel   = 1'b0;
`endif
endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue (default build, release edges ignored).
module tb_key_event_queue;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] button_in;
    logic       evt_valid, evt_ready, evt_rel, overflow, ovf_clr;
    logic [1:0] evt_key;
    logic [2:0] evt_count;
    int         total = 0;
    int         bad = 0;

    key_event_queue #(.DEPTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .button_in (button_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key   (evt_key),
        .evt_rel   (evt_rel),
        .evt_count (evt_count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // advance one edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input int cnt, input int key);
        chk({tag, ".cnt"}, int'(evt_count), cnt);
        chk({tag, ".vld"}, int'(evt_valid), cnt != 0);
        if (cnt != 0) chk({tag, ".key"}, int'(evt_key), key);
    endtask

    initial begin
        rst_n = 1'b0; button_in = 4'b1111; evt_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("rst.vld", int'(evt_valid), 0);
        chk("rst.cnt", int'(evt_count), 0);
        chk("rst.ovf", int'(overflow), 0);
        chk("rst.key", int'(evt_key), 0);
        chk("rst.rel", int'(evt_rel), 0);

        // single press, consumer ready: one cycle of valid, held key adds nothing
        evt_ready = 1'b1; button_in = 4'b1101;
        step(); head("p1", 1, 1);
        step(); head("p1.pop", 0, 0);
        repeat (3) step();
        head("p1.hold", 0, 0);
        button_in = 4'b1111; step();
        head("p1.rel", 0, 0);
        chk("p1.relflag", int'(evt_rel), 0);

        // simultaneous keys 0 and 3 queue in ascending order
        evt_ready = 1'b0; button_in = 4'b0110;
        step(); head("dual.a", 1, 0);
        step(); head("dual.b", 2, 0);
        evt_ready = 1'b1;
        step(); head("dual.pop1", 1, 3);
        step(); head("dual.pop2", 0, 0);
        evt_ready = 1'b0; button_in = 4'b1111; step();

        // fill: keys 0,1,2,3 fill the FIFO, fifth press (key 0) parks in pending
        for (int k = 0; k < 4; k++) begin
            button_in = ~(4'b0001 << k); step();
            button_in = 4'b1111;         step();
        end
        head("fill4", 4, 0);
        button_in = 4'b1110; step(); button_in = 4'b1111; step();
        head("fill.pend", 4, 0);
        chk("fill.ovf0", int'(overflow), 0);
        button_in = 4'b1110; step(); button_in = 4'b1111;
        chk("merge.ovf", int'(overflow), 1);
        step();
        chk("ovf.sticky", int'(overflow), 1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf.clr", int'(overflow), 0);

        // full FIFO, pop and press key 2 together: count holds, order kept
        evt_ready = 1'b1; button_in = 4'b1011;
        step(); head("full.pp", 4, 1);
        button_in = 4'b1111;
        step(); head("drain.a", 4, 2);
        step(); head("drain.b", 3, 3);
        step(); head("drain.c", 2, 0);
        step(); head("drain.d", 1, 2);
        step(); head("drain.e", 0, 0);
        chk("drain.ovf", int'(overflow), 0);

        // reset mid-queue with key 0 held through release
        evt_ready = 1'b0; button_in = 4'b1100;
        step(); step(); head("mid.q", 2, 0);
        #2 rst_n = 1'b0; #1;
        chk("mid.rst.cnt", int'(evt_count), 0);
        chk("mid.rst.vld", int'(evt_valid), 0);
        button_in = 4'b1110; step();
        head("mid.inrst", 0, 0);
        #2 rst_n = 1'b1;
        step(); head("held.press", 1, 0);
        step(); head("held.once", 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Consumer end of the debounced button interface: takes the 4-bit active-low button vector that the debouncer drives.
- Detects press edges, encodes each press as a 2-bit key index, and buffers the events in a small FIFO.
- Presents events to the game FSM over a valid/ready handshake, so no press is lost while the FSM is busy scoring or moving moles.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 3, width of evt_count; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- button_in  input  4  debounced buttons, active-low (4'b1111 = none pressed).
- evt_valid  output  1  head-of-queue event available.
- evt_ready  input  1  consumer accepts head event when evt_valid=1.
- evt_key  output  2  key index of head event (0..3).
- evt_rel  output  1  head event is a release (KEY_RELEASE_EN only; else constant 0).
- evt_count  output  CNT_W  number of events stored in the FIFO.
- overflow  output  1  sticky; an edge was lost.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync-to-clk use): prev register=4'b1111, pending mask=0, FIFO empty, evt_valid=0, evt_key=0, evt_rel=0, evt_count=0, overflow=0.
- Edge detect:
  - press[k] = prev[k] & ~button_in[k].
  - prev <= button_in every cycle.
- Candidate mask = pending | press.
  - Each cycle, if the FIFO can accept a push, the lowest-index set candidate is pushed.
  - Remaining candidate bits are stored in pending; pending clears each bit it pushes.
- FIFO can accept a push when evt_count < DEPTH, or when it is full and a pop occurs in the same cycle.
- Latency:
  - A press sampled at edge N with the FIFO empty and no pending bits is pushed at edge N.
  - evt_valid=1 after edge N; one cycle of latency.
- Pop: evt_valid & evt_ready at edge M removes the head. evt_key/evt_rel update to the next entry after edge M, or evt_valid drops to 0.
- Simultaneous push and pop: evt_count is unchanged; ordering is preserved.
- Simultaneous presses: multiple bits in one cycle are queued in ascending index order over successive cycles.
- Overflow:
  - A new press[k] while pending[k] is already 1 is merged (one event lost) and sets overflow.
  - Overflow is not set merely because the FIFO is full; pending absorbs up to one outstanding edge per key.
- ovf_clr=1 clears overflow at the next edge. A same-cycle new overflow condition wins; overflow stays 1.
- evt_valid = (evt_count != 0). Outputs evt_key/evt_rel come from the registered FIFO head, with no combinational path from button_in.
- Read/write pointers are log2(DEPTH) bits and wrap naturally; evt_count is tracked separately.
- Held buttons generate exactly one press event; no auto-repeat.
- Reset mid-operation: FIFO, pending and prev are discarded immediately. A button held through reset release is seen as prev=1 → press on the first sample.

Optional Feature:
- KEY_RELEASE_EN defined:
  - Release edges rel[k] = ~prev[k] & button_in[k] are also candidates.
  - Candidate order: press bits 0..3, then release bits 0..3.
  - FIFO entries are 3 bits {rel, key}; evt_rel is 1 for release events.
  - Pending becomes 8 bits; the merge/overflow rule applies per bit.
- KEY_RELEASE_EN undefined:
  - Release edges are ignored and entries are 2 bits.
  - evt_rel is driven constant 0.

Test Plan:
- Reset, button_in=4'b1111 idle for 20 cycles → evt_valid=0, evt_count=0, overflow=0.
- button_in 1111→1101 at edge N, evt_ready=1 → evt_valid=1 for exactly one cycle after N with evt_key=1; holding 1101 produces no further events.
- button_in 1111→0110 (keys 0 and 3) with evt_ready=0 → evt_count steps 1 then 2; popping yields evt_key=0, then 3.
- DEPTH=4, evt_ready=0:
  - Five distinct press cycles on keys 0,1,2,3,0 → evt_count=4, key 0 held in pending, overflow=0.
  - A sixth key-0 press → overflow=1.
  - ovf_clr=1 → overflow=0 next cycle.
- Full FIFO with evt_ready=1 and a new press in the same cycle → evt_count stays 4; popped order matches press order.
- KEY_RELEASE_EN: press then release key 2 with evt_ready=1 → events {rel=0,key=2} then {rel=1,key=2}. rst_n pulsed low mid-queue → evt_count=0 immediately.
